pe_stream_mux: RTL

Parametrised, registered N-to-1 stream multiplexer for the processing element datapath. It generalises the fixed 2-input word select to CHANNELS input streams of WIDTH bits each. Arbitration is either fixed-priority or round-robin, with an optional forced select that behaves like the legacy static switch. A single registered output stage with valid/ready handshake sits between the PE operand sources and the FPU/accumulator stage.

---
 rtl/pe_stream_mux_pkg.sv | 15 +
 rtl/pe_rr_arbiter.sv | 40 ++++
 rtl/pe_stream_mux.sv | 84 ++++++++
 3 files changed

// File: rtl/pe_stream_mux_pkg.sv
// Shared definitions for the PE stream multiplexer: arbitration mode codes and
// an index-width helper usable in parameter lists.
package pe_stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int pe_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pe_rr_arbiter.sv
// Combinational one-hot arbiter: fixed lowest-index priority or round-robin
// search starting just after rr_ptr, wrapping at CHANNELS-1.
module pe_rr_arbiter
  import pe_stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  localparam int CHAN_W  = pe_clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] eligible,
  input  logic [CHAN_W-1:0]   rr_ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CHAN_W-1:0]   grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MODE == MODE_RR) begin
        // rr_ptr never exceeds CHANNELS-1, so one subtraction is enough to wrap.
        idx = int'(rr_ptr) + 1 + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
      end else begin
        idx = k;
      end
      if (!found && eligible[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = CHAN_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pe_stream_mux.sv
// Registered N-to-1 stream multiplexer with valid/ready handshake, optional
// forced channel select and fixed-priority or round-robin arbitration.
module pe_stream_mux
  import pe_stream_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  localparam int CHAN_W  = pe_clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic                         force_en,
  input  logic [CHAN_W-1:0]            force_sel,
  output logic [WIDTH-1:0]             out_data,
  output logic [CHAN_W-1:0]            out_chan,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [CHANNELS-1:0] force_mask;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] grant;
  logic [CHAN_W-1:0]   grant_idx;
  logic [CHAN_W-1:0]   rr_ptr;
  logic [WIDTH-1:0]    grant_word;
  logic                load;
  logic                xfer;

  logic [WIDTH-1:0]    data_p1;
  logic [CHAN_W-1:0]   chan_p1;
  logic                vld_p1;

  // Out-of-range force_sel matches no channel, which blocks every request.
  always_comb begin
    force_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      force_mask[i] = (int'(force_sel) == i);
    end
  end

  assign eligible = force_en ? (in_valid & force_mask) : in_valid;

  pe_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load       = ~vld_p1 | out_ready;
  // rst_n gating keeps in_ready low while reset holds the register empty.
  assign in_ready   = grant & {CHANNELS{load & rst_n}};
  assign xfer       = |(in_valid & in_ready);
  assign grant_word = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  // Stage p0 -> p1: selected word captured into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      rr_ptr  <= CHAN_W'(CHANNELS - 1);
    end else if (load) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= grant_word;
        chan_p1 <= grant_idx;
        if (MODE == MODE_RR) rr_ptr <= grant_idx;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule
